expr_check_arbiter: RTL and testbench

Shares one expression checker between two byte-stream requesters. The checker accepts the grammar digit (op digit)*, where digit is '0'..'9' and op is '+' or '*'. A round-robin arbiter grants one requester for a whole string and feeds its bytes to the checker one per cycle. At end of string it returns a one-cycle verdict tagged with the owner. The block sits between the character sources and downstream logic that consumes pass/fail results.

---
 rtl/expr_check_arbiter.sv | 137 +++++++++++++
 tb/tb_expr_check_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_check_arbiter.sv
// Round-robin share of one "digit (op digit)*" checker between two byte-stream requesters.
// Optional build macro LEN_LIMIT_EN aborts a string that reaches MAX_LEN bytes without last.
module expr_check_arbiter #(
   parameter int MAX_LEN = 16
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       req0,
   input  logic [7:0] in0,
   input  logic       last0,
   input  logic       req1,
   input  logic [7:0] in1,
   input  logic       last1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done,
   output logic       result,
   output logic       owner,
   output logic       ovf
);

   localparam int LW = $clog2(MAX_LEN + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DONE = 2'd2} state_t;

   state_t        state, state_nx;
   logic          gnt0_nx, gnt1_nx, done_nx, result_nx, owner_nx, ovf_nx;
   logic          rr, rr_nx;
   logic          cs, cs_nx;          // 0 = S0 (expect digit), 1 = S1 (expect op)
   logic          err, err_nx;
   logic [LW-1:0] len, len_nx;

   logic          req_o, last_o, is_digit, is_op, ok_byte;
   logic          chk_err, chk_cs, lim_hit;
   logic [7:0]    byte_o;
   logic [LW-1:0] len_inc;

   assign req_o    = owner ? req1  : req0;
   assign byte_o   = owner ? in1   : in0;
   assign last_o   = owner ? last1 : last0;
   assign is_digit = (byte_o >= 8'h30) && (byte_o <= 8'h39);
   assign is_op    = (byte_o == 8'h2B) || (byte_o == 8'h2A);
   assign ok_byte  = cs ? is_op : is_digit;
   assign chk_err  = err | ~ok_byte;
   assign chk_cs   = ok_byte ? ~cs : cs;
   assign len_inc  = (len == LW'(MAX_LEN)) ? len : len + LW'(1);

`ifdef LEN_LIMIT_EN
   assign lim_hit  = (len_inc == LW'(MAX_LEN));
`else
   assign lim_hit  = 1'b0;
`endif

   always_comb begin
      state_nx  = state;
      gnt0_nx   = gnt0;
      gnt1_nx   = gnt1;
      done_nx   = 1'b0;
      result_nx = result;
      owner_nx  = owner;
      ovf_nx    = ovf;
      rr_nx     = rr;
      cs_nx     = cs;
      err_nx    = err;
      len_nx    = len;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               // both asking: the pointer decides; otherwise whoever asks
               owner_nx = (req0 && req1) ? rr : req1;
               gnt0_nx  = ~owner_nx;
               gnt1_nx  = owner_nx;
               cs_nx    = 1'b0;
               err_nx   = 1'b0;
               len_nx   = '0;
               state_nx = FEED;
            end
         end
         FEED: begin
            if (req_o) begin
               cs_nx  = chk_cs;
               err_nx = chk_err;
               len_nx = len_inc;
               if (last_o) begin
                  result_nx = ~chk_err & chk_cs;
                  ovf_nx    = 1'b0;
                  gnt0_nx   = 1'b0;
                  gnt1_nx   = 1'b0;
                  done_nx   = 1'b1;
                  state_nx  = DONE;
               end else if (lim_hit) begin
                  result_nx = 1'b0;
                  ovf_nx    = 1'b1;
                  gnt0_nx   = 1'b0;
                  gnt1_nx   = 1'b0;
                  done_nx   = 1'b1;
                  state_nx  = DONE;
               end
            end
         end
         DONE: begin
            rr_nx    = ~owner;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state  <= IDLE;
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         done   <= 1'b0;
         result <= 1'b0;
         owner  <= 1'b0;
         ovf    <= 1'b0;
         rr     <= 1'b0;
         cs     <= 1'b0;
         err    <= 1'b0;
         len    <= '0;
      end else begin
         state  <= state_nx;
         gnt0   <= gnt0_nx;
         gnt1   <= gnt1_nx;
         done   <= done_nx;
         result <= result_nx;
         owner  <= owner_nx;
         ovf    <= ovf_nx;
         rr     <= rr_nx;
         cs     <= cs_nx;
         err    <= err_nx;
         len    <= len_nx;
      end
   end

endmodule

// File: tb/tb_expr_check_arbiter.sv
// Randomized + directed bench for expr_check_arbiter against a transaction-level model.
module tb_expr_check_arbiter;
   localparam int MAXL = 4;
`ifdef LEN_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   logic       clk = 1'b0, clr;
   logic       req0, last0, req1, last1;
   logic [7:0] in0, in1;
   logic       gnt0, gnt1, done, result, owner, ovf;

   always #5 clk = ~clk;

   expr_check_arbiter #(.MAX_LEN(MAXL)) dut (
      .clk(clk), .clr(clr),
      .req0(req0), .in0(in0), .last0(last0),
      .req1(req1), .in1(in1), .last1(last1),
      .gnt0(gnt0), .gnt1(gnt1), .done(done),
      .result(result), .owner(owner), .ovf(ovf));

   int pass_cnt = 0, chk_cnt = 0;

   // driver state per requester
   string      q0[$], q1[$];
   string      cur[2];
   int         pos[2], gap_pos[2], gap_len[2], hold[2];
   bit         act[2], dreq[2], dlast[2];
   logic [7:0] dbyte[2];
   bit         rnd_stall;

   // model: 0 free, 1 string in progress, 2 verdict cycle
   int phase, mown, last_srv, stallc;
   bit m_res, m_ovf;
   int log_own[$], log_res[$], log_ovf[$];

   task automatic check(string name, int act_v, int exp_v);
      chk_cnt++;
      if (act_v == exp_v) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
   endtask

   function automatic void verdict(string s, output bit r, output bit o);
      int n = s.len();
      byte c;
      o = 1'b0;
      if (LIM && n > MAXL) begin
         r = 1'b0; o = 1'b1; return;
      end
      r = (n % 2 == 1);
      for (int i = 0; i < n; i++) begin
         c = s[i];
         if (i % 2 == 0) r &= (c >= 8'h30 && c <= 8'h39);
         else            r &= (c == 8'h2B || c == 8'h2A);
      end
   endfunction

   task automatic drive_ports();
      req0 = dreq[0]; in0 = dbyte[0]; last0 = dlast[0];
      req1 = dreq[1]; in1 = dbyte[1]; last1 = dlast[1];
   endtask

   task automatic step();
      bit r, o, ended;
      string s;
      @(posedge clk);
      @(negedge clk);
      // what the edge just past did
      case (phase)
         0: if (dreq[0] || dreq[1]) begin
               mown  = (dreq[0] && dreq[1]) ? 1 - last_srv : (dreq[1] ? 1 : 0);
               phase = 1;
            end
         1: if (dreq[mown]) begin
               pos[mown]++;
               ended = dlast[mown] || (LIM && pos[mown] == MAXL);
               if (ended) begin
                  verdict(cur[mown], r, o);
                  m_res = r; m_ovf = o;
                  act[mown] = 1'b0;
                  phase = 2;
               end
            end
         default: begin last_srv = mown; phase = 0; end
      endcase
      check("gnt0", gnt0, (phase == 1 && mown == 0));
      check("gnt1", gnt1, (phase == 1 && mown == 1));
      check("done", done, (phase == 2));
      check("result", result, m_res);
      check("ovf", ovf, m_ovf);
      if (phase == 2) begin
         check("owner", owner, mown);
         log_own.push_back(mown); log_res.push_back(m_res); log_ovf.push_back(m_ovf);
      end
      if (gnt0 && !dreq[0]) stallc++;
      for (int i = 0; i < 2; i++) begin
         if (!act[i]) begin
            if (hold[i] > 0) hold[i]--;
            else if (i == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); pos[0] = 0; act[0] = 1'b1; end
            else if (i == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); pos[1] = 0; act[1] = 1'b1; end
         end
         dreq[i]  = 1'b0;
         dbyte[i] = 8'($urandom);
         dlast[i] = 1'($urandom);
         if (act[i]) begin
            s = cur[i];
            dbyte[i] = s[pos[i]];
            dlast[i] = (pos[i] == s.len() - 1);
            if (gap_len[i] > 0 && pos[i] == gap_pos[i]) gap_len[i]--;
            else if (rnd_stall && $urandom_range(3) == 0) dreq[i] = 1'b0;
            else dreq[i] = 1'b1;
         end
      end
      drive_ports();
   endtask

   task automatic run(int budget);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || act[0] || act[1] || phase != 0) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) begin
         chk_cnt++;
         $display("FAIL timeout: still busy after %0d cycles, expected idle", budget);
      end
   endtask

   task automatic clear_log();
      log_own.delete(); log_res.delete(); log_ovf.delete();
   endtask

   task automatic expect_log(int idx, int o, int r, int v);
      if (idx >= log_own.size()) begin
         chk_cnt++;
         $display("FAIL verdict_%0d: missing, expected owner %0d result %0d", idx, o, r);
      end else begin
         check($sformatf("v%0d_owner", idx), log_own[idx], o);
         check($sformatf("v%0d_result", idx), log_res[idx], r);
         check($sformatf("v%0d_ovf", idx), log_ovf[idx], v);
      end
   endtask

   task automatic do_reset();
      clr = 1'b1;
      #1;
      check("rst_gnt0", gnt0, 0);   check("rst_gnt1", gnt1, 0);
      check("rst_done", done, 0);   check("rst_result", result, 0);
      check("rst_owner", owner, 0); check("rst_ovf", ovf, 0);
      phase = 0; mown = 0; last_srv = 1; m_res = 1'b0; m_ovf = 1'b0;
      q0.delete(); q1.delete();
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0; dreq[i] = 1'b0; dlast[i] = 1'b0; dbyte[i] = 8'h00;
         pos[i] = 0; gap_len[i] = 0; gap_pos[i] = 0; hold[i] = 0;
      end
      drive_ports();
      @(negedge clk);
      clr = 1'b0;
   endtask

   function automatic string rand_str();
      string cs = "0123456789+*= ";
      string dg = "0123456789";
      string op = "+*";
      string s = "";
      int n = $urandom_range(7, 1);
      int k;
      for (int j = 0; j < n; j++) begin
         if ($urandom_range(7) == 0) begin k = $urandom_range(13); s = {s, cs.substr(k, k)}; end
         else if (j % 2 == 0)        begin k = $urandom_range(9);  s = {s, dg.substr(k, k)}; end
         else                        begin k = $urandom_range(1);  s = {s, op.substr(k, k)}; end
      end
      return s;
   endfunction

   initial begin
      int n;
      rnd_stall = 1'b0;
      stallc = 0;
      clr = 1'b1;
      @(negedge clk);
      do_reset();

      // single requester, valid expression
      clear_log();
      q0.push_back("1+2*3");
      run(100);
      expect_log(0, 0, 1, 0);

      // malformed, multi-digit, single digit
      clear_log();
      q1.push_back("1++2"); q1.push_back("12"); q1.push_back("7");
      run(200);
      expect_log(0, 1, 0, 0); expect_log(1, 1, 0, 0); expect_log(2, 1, 1, 0);

      // simultaneous requests: pointer starts at requester 0
      do_reset();
      clear_log();
      q0.push_back("4*5"); q1.push_back("4*5");
      run(200);
      expect_log(0, 0, 1, 0); expect_log(1, 1, 1, 0);
      // serve requester 0 alone, pointer flips to 1, then both again
      q0.push_back("4*5");
      run(100);
      q0.push_back("4*5"); q1.push_back("4*5");
      run(200);
      expect_log(2, 0, 1, 0); expect_log(3, 1, 1, 0); expect_log(4, 0, 1, 0);

      // owner stalls three cycles mid-string while the other requester waits
      clear_log();
      stallc = 0;
      gap_pos[0] = 2; gap_len[0] = 3; hold[1] = 2;
      q0.push_back("9+8"); q1.push_back("1");
      run(200);
      check("stall_cycles", stallc, 3);
      expect_log(0, 0, 1, 0); expect_log(1, 1, 1, 0);

      // reset mid-string aborts without a verdict
      clear_log();
      q0.push_back("3+4");
      n = 0;
      while (pos[0] < 2 && n < 50) begin step(); n++; end
      do_reset();
      repeat (3) step();
      check("abort_verdicts", log_own.size(), 0);
      q0.push_back("3+4");
      run(100);
      expect_log(0, 0, 1, 0);

      // length boundary
      clear_log();
      q0.push_back("1+2+3"); q0.push_back("1+2*");
      run(200);
      if (LIM) expect_log(0, 0, 0, 1);
      else     expect_log(0, 0, 1, 0);
      expect_log(1, 0, 0, 0);

      // random traffic with random stalls
      rnd_stall = 1'b1;
      for (int i = 0; i < 40; i++) begin
         q0.push_back(rand_str());
         q1.push_back(rand_str());
      end
      run(8000);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
